alu_share_arb: RTL and testbench

Round-robin arbiter that shares the single combinational 32-bit ALU between two execution requesters, such as the integer pipe and the address/branch helper. The arbiter sits between the requesters and the ALU instance. It drives the ALU's 12-bit one-hot control and both operands from the granted request, and registers the ALU result into a per-requester response slot. Both the request and response sides use valid/ready handshakes.

---
 rtl/alu_share_arb.sv | 111 +++++++++++
 tb/tb_alu_share_arb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// Shares one combinational 32-bit ALU between two valid/ready requesters and
// registers each result into a per-requester slot. Macro ALU_SHARE_ARB_RR_EN selects round-robin; otherwise requester 0 has fixed priority.
module alu_share_arb #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [11:0]      req0_op,
    input  logic [31:0]      req0_src1,
    input  logic [31:0]      req0_src2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [11:0]      req1_op,
    input  logic [31:0]      req1_src1,
    input  logic [31:0]      req1_src2,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_result,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_result,
    output logic [11:0]      alu_control,
    output logic [31:0]      alu_src1,
    output logic [31:0]      alu_src2,
    input  logic [31:0]      alu_result,
    output logic [CNT_W-1:0] conflict_cnt
);

    logic elig0, elig1;
    logic grant0, grant1;

    // A full slot that is not draining this cycle has nowhere to put a result.
    assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
    assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

`ifdef ALU_SHARE_ARB_RR_EN
    logic last_grant;

    // On a conflict the requester that did not win last time goes first.
    assign grant0 = elig0 & (~elig1 | last_grant);
    assign grant1 = elig1 & (~elig0 | ~last_grant);

    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= 1'b1;
        else if (grant0)
            last_grant <= 1'b0;
        else if (grant1)
            last_grant <= 1'b1;
    end
`else
    assign grant0 = elig0;
    assign grant1 = elig1 & ~elig0;
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        alu_control = '0;
        alu_src1    = '0;
        alu_src2    = '0;
        if (grant0) begin
            alu_control = req0_op;
            alu_src1    = req0_src1;
            alu_src2    = req0_src2;
        end else if (grant1) begin
            alu_control = req1_op;
            alu_src1    = req1_src1;
            alu_src2    = req1_src2;
        end
    end

    // A new grant wins over a drain on the same slot, so valid stays high.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
        end else if (grant0) begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= alu_result;
        end else if (rsp0_valid && rsp0_ready) begin
            rsp0_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
        end else if (grant1) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= alu_result;
        end else if (rsp1_valid && rsp1_ready) begin
            rsp1_valid  <= 1'b0;
        end
    end

    // Saturating count of cycles where both requesters could have been served.
    always_ff @(posedge clk) begin
        if (reset)
            conflict_cnt <= '0;
        else if (elig0 && elig1 && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: table of per-cycle vectors plus reset and
// saturation sequences; expectations follow ALU_SHARE_ARB_RR_EN when it is defined.
module tb_alu_share_arb;

    localparam int CNT_W = 4;
`ifdef ALU_SHARE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [11:0] OP_ADD  = 12'h800;
    localparam logic [11:0] OP_SUB  = 12'h400;
    localparam logic [11:0] OP_SLTU = 12'h080;
    localparam logic [11:0] OP_LUI  = 12'h001;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [11:0]      req0_op, req1_op;
    logic [31:0]      req0_src1, req0_src2, req1_src1, req1_src2;
    logic             rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0]      rsp0_result, rsp1_result;
    logic [11:0]      alu_control;
    logic [31:0]      alu_src1, alu_src2, alu_result;
    logic [CNT_W-1:0] conflict_cnt;

    int errors = 0;
    int checks = 0;

    alu_share_arb #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_src1(req0_src1), .req0_src2(req0_src2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_src1(req1_src1), .req1_src2(req1_src2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .alu_control(alu_control), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_result(alu_result), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared ALU (only the ops used here).
    function automatic logic [31:0] alu_model(logic [11:0] c, logic [31:0] a, logic [31:0] b);
        case (c)
            12'h800: return a + b;
            12'h400: return a - b;
            12'h080: return {31'b0, a < b};
            12'h001: return b;
            default: return 32'h0;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_control, alu_src1, alu_src2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Requester obligation: a pending (valid, not ready) request stays stable.
    logic        p0_pend = 1'b0, p1_pend = 1'b0;
    logic [75:0] p0_req, p1_req;
    always @(posedge clk) begin
        if (!reset && p0_pend && req0_valid)
            check("req0 stable", {31'b0, {req0_op, req0_src1, req0_src2} == p0_req}, 32'd1);
        if (!reset && p1_pend && req1_valid)
            check("req1 stable", {31'b0, {req1_op, req1_src1, req1_src2} == p1_req}, 32'd1);
        p0_pend <= req0_valid & ~req0_ready;
        p1_pend <= req1_valid & ~req1_ready;
        p0_req  <= {req0_op, req0_src1, req0_src2};
        p1_req  <= {req1_op, req1_src1, req1_src2};
    end

    typedef struct {
        logic        v0;  logic [11:0] op0; logic [31:0] a0; logic [31:0] b0;
        logic        v1;  logic [11:0] op1; logic [31:0] a1; logic [31:0] b1;
        logic        r0;  logic        r1;
        logic        eg0; logic        eg1;
        logic [11:0] ectl; logic [31:0] es1; logic [31:0] es2;
        logic        ev0; logic [31:0] eres0;
        logic        ev1; logic [31:0] eres1;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t vecs[16];

    task automatic drive(input logic v0, input logic [11:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [11:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic r0, input logic r1);
        req0_valid = v0; req0_op = op0; req0_src1 = a0; req0_src2 = b0;
        req1_valid = v1; req1_op = op1; req1_src1 = a1; req1_src2 = b1;
        rsp0_ready = r0; rsp1_ready = r1;
    endtask

    initial begin
        // Conflict phase: rows 1..6 depend on the arbitration mode.
        vecs[0]  = '{1, OP_ADD, 1, 1, 1, OP_SUB, 9, 4, 1, 1, 1, 0, OP_ADD, 1, 1, 1, 2, 0, 0, 1};
        vecs[1]  = '{1, OP_ADD, 1, 1, 1, OP_SUB, 9, 4, 1, 1, ~RR, RR, RR ? OP_SUB : OP_ADD,
                     RR ? 32'd9 : 32'd1, RR ? 32'd4 : 32'd1, ~RR, 2, RR, RR ? 32'd5 : 32'd0, 2};
        vecs[2]  = '{1, OP_ADD, 1, 1, 1, OP_SUB, 9, 4, 1, 1, 1, 0, OP_ADD, 1, 1, 1, 2, 0, RR ? 32'd5 : 32'd0, 3};
        vecs[3]  = '{1, OP_ADD, 1, 1, 1, OP_SUB, 9, 4, 1, 1, ~RR, RR, RR ? OP_SUB : OP_ADD,
                     RR ? 32'd9 : 32'd1, RR ? 32'd4 : 32'd1, ~RR, 2, RR, RR ? 32'd5 : 32'd0, 4};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2, 0, RR ? 32'd5 : 32'd0, 4};
        // Single requester, back-to-back throughput.
        vecs[5]  = '{1, OP_ADD, 5, 3, 0, 0, 0, 0, 1, 1, 1, 0, OP_ADD, 5, 3, 1, 8, 0, RR ? 32'd5 : 32'd0, 4};
        vecs[6]  = '{1, OP_ADD, 32'h10, 32'h20, 0, 0, 0, 0, 1, 1, 1, 0, OP_ADD, 32'h10, 32'h20, 1, 32'h30, 0, RR ? 32'd5 : 32'd0, 4};
        // Backpressure on slot 1, then release with same-cycle regrant.
        vecs[7]  = '{0, 0, 0, 0, 1, OP_SUB, 1, 2, 1, 0, 0, 1, OP_SUB, 1, 2, 0, 32'h30, 1, 32'hFFFFFFFF, 4};
        vecs[8]  = '{1, OP_ADD, 7, 7, 1, OP_SUB, 3, 1, 1, 0, 1, 0, OP_ADD, 7, 7, 1, 32'hE, 1, 32'hFFFFFFFF, 4};
        vecs[9]  = '{1, OP_ADD, 7, 7, 1, OP_SUB, 3, 1, 1, 0, 1, 0, OP_ADD, 7, 7, 1, 32'hE, 1, 32'hFFFFFFFF, 4};
        vecs[10] = '{0, 0, 0, 0, 1, OP_SUB, 3, 1, 1, 1, 0, 1, OP_SUB, 3, 1, 0, 32'hE, 1, 2, 4};
        // Drain and reload of slot 0 in the same cycle, zero op, lui.
        vecs[11] = '{1, OP_ADD, 4, 4, 0, 0, 0, 0, 1, 1, 1, 0, OP_ADD, 4, 4, 1, 8, 0, 2, 4};
        vecs[12] = '{1, OP_SLTU, 1, 2, 0, 0, 0, 0, 1, 1, 1, 0, OP_SLTU, 1, 2, 1, 1, 0, 2, 4};
        vecs[13] = '{1, 0, 32'h1234, 32'h5678, 0, 0, 0, 0, 1, 1, 1, 0, 0, 32'h1234, 32'h5678, 1, 0, 0, 2, 4};
        vecs[14] = '{0, 0, 0, 0, 1, OP_LUI, 0, 32'hABCDE000, 1, 1, 0, 1, OP_LUI, 0, 32'hABCDE000, 0, 0, 1, 32'hABCDE000, 4};
        // Fill both slots with no drain ahead of the mid-operation reset.
        vecs[15] = '{1, OP_ADD, 1, 2, 1, OP_ADD, 3, 4, 0, 0, 1, 0, OP_ADD, 1, 2, 1, 3, 1, 32'hABCDE000, 4};

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset rsp0_valid", rsp0_valid, 0);
        check("reset rsp1_valid", rsp1_valid, 0);
        check("reset rsp0_result", rsp0_result, 0);
        check("reset rsp1_result", rsp1_result, 0);
        check("reset cnt", conflict_cnt, 0);
        check("reset req0_ready", req0_ready, 0);
        check("reset req1_ready", req1_ready, 0);
        check("reset alu_control", alu_control, 0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(vecs[i].v0, vecs[i].op0, vecs[i].a0, vecs[i].b0,
                  vecs[i].v1, vecs[i].op1, vecs[i].a1, vecs[i].b1, vecs[i].r0, vecs[i].r1);
            #1;
            check($sformatf("v%0d req0_ready", i), req0_ready, vecs[i].eg0);
            check($sformatf("v%0d req1_ready", i), req1_ready, vecs[i].eg1);
            check($sformatf("v%0d alu_control", i), alu_control, vecs[i].ectl);
            check($sformatf("v%0d alu_src1", i), alu_src1, vecs[i].es1);
            check($sformatf("v%0d alu_src2", i), alu_src2, vecs[i].es2);
            @(posedge clk);
            #1;
            check($sformatf("v%0d rsp0_valid", i), rsp0_valid, vecs[i].ev0);
            check($sformatf("v%0d rsp0_result", i), rsp0_result, vecs[i].eres0);
            check($sformatf("v%0d rsp1_valid", i), rsp1_valid, vecs[i].ev1);
            check($sformatf("v%0d rsp1_result", i), rsp1_result, vecs[i].eres1);
            check($sformatf("v%0d conflict_cnt", i), conflict_cnt, vecs[i].ecnt);
        end

        // Reset while both slots hold results.
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("midreset rsp0_valid", rsp0_valid, 0);
        check("midreset rsp1_valid", rsp1_valid, 0);
        check("midreset rsp0_result", rsp0_result, 0);
        check("midreset cnt", conflict_cnt, 0);

        @(negedge clk);
        reset = 1'b0;
        drive(1, OP_ADD, 1, 1, 1, OP_ADD, 2, 2, 1, 1);
        #1;
        check("postreset req0_ready", req0_ready, 1);
        check("postreset req1_ready", req1_ready, 0);
        @(posedge clk);
        #1;
        check("postreset rsp0_result", rsp0_result, 2);
        check("postreset cnt", conflict_cnt, 1);

        // 20 more conflict cycles: counter must stop at all-ones.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat cnt %0d", i), conflict_cnt, (i + 2 > 15) ? 32'd15 : 32'(i + 2));
        end

        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
